// File: rtl/rotary_paddle_decoder_if.sv
// Pin and status bundle between the rotary encoder front end and the Pong game logic.
interface rotary_paddle_decoder_if;
  logic       rota;
  logic       rotb;
  logic [9:0] paddle_pos;
  logic       step_pulse;
  logic       step_dir;
  logic       at_min;
  logic       at_max;

  modport slave  (input  rota, rotb,
                  output paddle_pos, step_pulse, step_dir, at_min, at_max);
  modport master (output rota, rotb,
                  input  paddle_pos, step_pulse, step_dir, at_min, at_max);
endinterface

// File: rtl/rotary_paddle_decoder.sv
// Quadrature encoder -> clamped paddle position: sync, debounce, detent decode, saturating update.
// Optional macro ROTARY_ACCEL_EN: quadruple step when detents arrive within ACCEL_WINDOW cycles.
module rotary_paddle_decoder #(
  parameter logic [9:0]  PADDLE_MIN      = 10'd0,
  parameter logic [9:0]  PADDLE_MAX      = 10'd416,
  parameter logic [9:0]  RESET_POS       = 10'd208,
  parameter logic [9:0]  STEP            = 10'd8,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`ifdef ROTARY_ACCEL_EN
  , parameter logic [23:0] ACCEL_WINDOW  = 24'd2000000
`endif
) (
  input  logic CLK,
  input  logic RESET,
  rotary_paddle_decoder_if.slave bus
);

  // Channel index 1 = A, 0 = B, so r_filt reads as {a_f, b_f}.
  logic [1:0]       w_raw;
  logic [1:0]       r_meta, r_sync, r_filt;
  logic [1:0][15:0] r_cnt;

  assign w_raw = {bus.rota, bus.rotb};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_meta <= 2'b11;
      r_sync <= 2'b11;
      r_filt <= 2'b11;
      r_cnt  <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          r_filt[i] <= r_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  // q1 arms on 00 and disarms on 11; q2 remembers which single-high phase preceded it.
  logic r_q1, r_q2, r_q1_d;
  logic w_event;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_q1   <= 1'b0;
      r_q2   <= 1'b0;
      r_q1_d <= 1'b0;
    end else begin
      case (r_filt)
        2'b00:   r_q1 <= 1'b1;
        2'b11:   r_q1 <= 1'b0;
        2'b01:   r_q2 <= 1'b0;
        2'b10:   r_q2 <= 1'b1;
        default: ;
      endcase
      r_q1_d <= r_q1;
    end
  end

  assign w_event = r_q1 & ~r_q1_d;

  logic [10:0] w_step;

`ifdef ROTARY_ACCEL_EN
  // Starts saturated so the first detent after reset never accelerates.
  logic [23:0] r_ivl;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)              r_ivl <= '1;
    else if (w_event)        r_ivl <= '0;
    else if (r_ivl != '1)    r_ivl <= r_ivl + 24'd1;
  end

  assign w_step = (r_ivl < ACCEL_WINDOW) ? ({1'b0, STEP} << 2) : {1'b0, STEP};
`else
  assign w_step = {1'b0, STEP};
`endif

  logic [9:0]  r_pos;
  logic        r_pulse, r_dir, r_min, r_max;
  logic [10:0] w_sum;
  logic [9:0]  w_inc, w_dec, w_next;

  assign w_sum  = {1'b0, r_pos} + w_step;
  assign w_inc  = (w_sum > {1'b0, PADDLE_MAX}) ? PADDLE_MAX : w_sum[9:0];
  assign w_dec  = ({1'b0, r_pos} < ({1'b0, PADDLE_MIN} + w_step)) ? PADDLE_MIN
                                                                  : (r_pos - w_step[9:0]);
  assign w_next = r_q2 ? w_dec : w_inc;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pos   <= RESET_POS;
      r_pulse <= 1'b0;
      r_dir   <= 1'b0;
      r_min   <= (RESET_POS == PADDLE_MIN);
      r_max   <= (RESET_POS == PADDLE_MAX);
    end else begin
      r_pulse <= w_event;
      if (w_event) begin
        r_dir <= ~r_q2;
        r_pos <= w_next;
        r_min <= (w_next == PADDLE_MIN);
        r_max <= (w_next == PADDLE_MAX);
      end
    end
  end

  assign bus.paddle_pos = r_pos;
  assign bus.step_pulse = r_pulse;
  assign bus.step_dir   = r_dir;
  assign bus.at_min     = r_min;
  assign bus.at_max     = r_max;

endmodule

// File: tb/tb_rotary_paddle_decoder.sv
// Scoreboard bench: detent stimulus pushes expected pulses, a monitor checks each step_pulse.
module tb_rotary_paddle_decoder;
  localparam logic [15:0] D  = 16'd4;
  localparam int          PH = 12;
  localparam int          W  = 100;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  rotary_paddle_decoder_if bus();

  rotary_paddle_decoder #(
    .DEBOUNCE_CYCLES(D)
`ifdef ROTARY_ACCEL_EN
    , .ACCEL_WINDOW(24'(W))
`endif
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    int pos;
    int dir;
    int amin;
    int amax;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   m_pos;
  bit   m_first;
  int   m_last;
  logic [9:0] prev_pos;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RESET) begin
      if (bus.paddle_pos !== prev_pos) chk("pos_moves_only_on_pulse", int'(bus.step_pulse), 1);
      prev_pos = bus.paddle_pos;
      if (bus.step_pulse === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_pos",   int'(bus.paddle_pos), e.pos);
          chk("pulse_dir",   int'(bus.step_dir),   e.dir);
          chk("pulse_atmin", int'(bus.at_min),     e.amin);
          chk("pulse_atmax", int'(bus.at_max),     e.amax);
          chk("pulse_cycle", cyc,                  e.cyc);
        end
      end
    end else begin
      prev_pos = bus.paddle_pos;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic set_pins(input logic a, input logic b);
    @(posedge CLK);
    #1;
    bus.rota = a;
    bus.rotb = b;
  endtask

  task automatic model_reset();
    m_pos   = 208;
    m_first = 1'b1;
    m_last  = 0;
    q.delete();
  endtask

  // Called right after the pins reach 00; the pulse is due D+4 cycles later.
  task automatic push_event(input bit inc);
    exp_t e;
    int   step;
    e.cyc = cyc + int'(D) + 4;
    step  = 8;
`ifdef ROTARY_ACCEL_EN
    if (!m_first && (e.cyc - m_last) <= W) step = 32;
`endif
    m_first = 1'b0;
    m_last  = e.cyc;
    if (inc) m_pos = (m_pos + step > 416) ? 416 : m_pos + step;
    else     m_pos = (m_pos < step) ? 0 : m_pos - step;
    e.pos  = m_pos;
    e.dir  = inc ? 1 : 0;
    e.amin = (m_pos == 0)   ? 1 : 0;
    e.amax = (m_pos == 416) ? 1 : 0;
    q.push_back(e);
  endtask

  // Increment: 11->01->00->10->11; decrement: 11->10->00->01->11.
  task automatic detent(input bit inc, input bit bounce);
    logic [1:0] ph [4];
    if (inc) begin ph[0] = 2'b01; ph[1] = 2'b00; ph[2] = 2'b10; ph[3] = 2'b11; end
    else     begin ph[0] = 2'b10; ph[1] = 2'b00; ph[2] = 2'b01; ph[3] = 2'b11; end
    for (int p = 0; p < 4; p++) begin
      set_pins(ph[p][1], ph[p][0]);
      if (p == 1) push_event(inc);
      hold(PH);
      if (bounce) begin
        @(posedge CLK); #1 bus.rota = ~bus.rota;
        repeat (2) @(posedge CLK);
        #1 bus.rota = ~bus.rota;
        hold(PH);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET    = 1'b0;
    bus.rota = 1'b1;
    bus.rotb = 1'b1;
    model_reset();
    hold(5);
    #1 RESET = 1'b1;
    hold(10);
  endtask

  initial begin
    bus.rota = 1'b1;
    bus.rotb = 1'b1;
    model_reset();
    hold(3);
    #1;
    chk("reset_pos",   int'(bus.paddle_pos), 208);
    chk("reset_pulse", int'(bus.step_pulse), 0);
    chk("reset_dir",   int'(bus.step_dir),   0);
    chk("reset_atmin", int'(bus.at_min),     0);
    chk("reset_atmax", int'(bus.at_max),     0);
    RESET = 1'b1;
    hold(100);
    chk("idle_pos", int'(bus.paddle_pos), 208);

    detent(1'b1, 1'b0);
    hold(10);
    chk("inc_pos", int'(bus.paddle_pos), 216);
    chk("inc_dir", int'(bus.step_dir),   1);

    do_reset();
    detent(1'b0, 1'b1);
    hold(10);
    chk("bounce_dec_pos", int'(bus.paddle_pos), 200);
    chk("bounce_dec_dir", int'(bus.step_dir),   0);

    do_reset();
    for (int i = 0; i < 60; i++) detent(1'b1, 1'b0);
    hold(10);
    chk("sat_max_pos",  int'(bus.paddle_pos), 416);
    chk("sat_max_flag", int'(bus.at_max),     1);
    for (int i = 0; i < 60; i++) detent(1'b0, 1'b0);
    hold(10);
    chk("sat_min_pos",  int'(bus.paddle_pos), 0);
    chk("sat_min_flag", int'(bus.at_min),     1);
    chk("sat_min_maxf", int'(bus.at_max),     0);

    do_reset();
    detent(1'b1, 1'b0);
    hold(150);
    detent(1'b1, 1'b0);
    hold(10);
    chk("slow_pair_pos", int'(bus.paddle_pos), 224);

    do_reset();
    set_pins(1'b0, 1'b1);
    hold(PH);
    set_pins(1'b0, 1'b0);
    hold(3);
    #1;
    RESET    = 1'b0;
    bus.rota = 1'b1;
    bus.rotb = 1'b1;
    hold(4);
    #1 RESET = 1'b1;
    hold(60);
    chk("abort_pos",   int'(bus.paddle_pos), 208);
    chk("abort_atmin", int'(bus.at_min),     0);

    hold(20);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
